// File: rtl/id_operand_stage.sv
// id_operand_stage: decode-stage operand fetch with EX/MEM/WB forwarding, load-use stall FSM and ID/EX register; ID_STALL_CNT_EN adds a saturating stall counter output
module id_operand_stage #(
  parameter int WIDTH    = 32,
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic             Clk,
  input  logic             Clr_n,
  input  logic             ID_valid,
  input  logic [AW-1:0]    RA_in,
  input  logic [AW-1:0]    RB_in,
  output logic [AW-1:0]    RA,
  output logic [AW-1:0]    RB,
  input  logic [WIDTH-1:0] PA,
  input  logic [WIDTH-1:0] PB,
  input  logic [AW-1:0]    EX_rd,
  input  logic             EX_we,
  input  logic             EX_load,
  input  logic [WIDTH-1:0] EX_result,
  input  logic [AW-1:0]    MEM_rd,
  input  logic             MEM_we,
  input  logic [WIDTH-1:0] MEM_data,
  input  logic [AW-1:0]    WB_rd,
  input  logic             WB_we,
  input  logic [WIDTH-1:0] WB_data,
  input  logic             Flush,
  output logic             Stall,
  output logic [WIDTH-1:0] OPA,
  output logic [WIDTH-1:0] OPB,
  output logic             OP_valid,
  output logic [1:0]       FWD_A,
  output logic [1:0]       FWD_B
`ifdef ID_STALL_CNT_EN
  ,
  output logic [15:0]      STALL_CNT
`endif
);
  typedef enum logic {RUN, HOLD} state_t;
  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, val_a, val_b;
  logic             op_valid_q, op_valid_d, hazard;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d, sel_a, sel_b;
  assign RA       = RA_in;
  assign RB       = RB_in;
  assign OPA      = opa_q;
  assign OPB      = opb_q;
  assign OP_valid = op_valid_q;
  assign FWD_A    = fwd_a_q;
  assign FWD_B    = fwd_b_q;
  // forward select per operand, youngest producer wins; register 0 is hard zero
  always_comb begin
    sel_a  = (RA_in == '0) ? 2'd0 :
             (EX_we && EX_rd == RA_in) ? 2'd3 :
             (MEM_we && MEM_rd == RA_in) ? 2'd2 :
             (WB_we && WB_rd == RA_in) ? 2'd1 : 2'd0;
    sel_b  = (RB_in == '0) ? 2'd0 :
             (EX_we && EX_rd == RB_in) ? 2'd3 :
             (MEM_we && MEM_rd == RB_in) ? 2'd2 :
             (WB_we && WB_rd == RB_in) ? 2'd1 : 2'd0;
    val_a  = (RA_in == '0) ? '0 : (sel_a == 2'd3) ? EX_result : (sel_a == 2'd2) ? MEM_data :
             (sel_a == 2'd1) ? WB_data : PA;
    val_b  = (RB_in == '0) ? '0 : (sel_b == 2'd3) ? EX_result : (sel_b == 2'd2) ? MEM_data :
             (sel_b == 2'd1) ? WB_data : PB;
    hazard = ID_valid && EX_we && EX_load && EX_rd != '0 && (EX_rd == RA_in || EX_rd == RB_in);
  end
  // stall FSM and ID/EX next values; anything but a clean RUN issue is a bubble
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    Stall      = 1'b0;
    opa_d      = '0;
    opb_d      = '0;
    op_valid_d = 1'b0;
    fwd_a_d    = 2'd0;
    fwd_b_d    = 2'd0;
    if (Flush) begin
      state_d = RUN;
      cnt_d   = 3'd0;
    end else if (state_q == HOLD) begin
      Stall   = 1'b1;
      cnt_d   = cnt_q - 3'd1;
      state_d = (cnt_q == 3'd1) ? RUN : HOLD;
    end else if (hazard) begin
      Stall   = 1'b1;
      cnt_d   = 3'(LOAD_LAT - 1);
      state_d = (LOAD_LAT == 1) ? RUN : HOLD;
    end else begin
      opa_d      = val_a;
      opb_d      = val_b;
      op_valid_d = ID_valid;
      fwd_a_d    = sel_a;
      fwd_b_d    = sel_b;
    end
  end
  // pipeline and FSM state registers
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      state_q    <= RUN;
      cnt_q      <= 3'd0;
      opa_q      <= '0;
      opb_q      <= '0;
      op_valid_q <= 1'b0;
      fwd_a_q    <= 2'd0;
      fwd_b_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      op_valid_q <= op_valid_d;
      fwd_a_q    <= fwd_a_d;
      fwd_b_q    <= fwd_b_d;
    end
  end
`ifdef ID_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  assign STALL_CNT = stall_cnt_q;
  // saturating count of stalled cycles, survives Flush
  always_comb stall_cnt_d = (Stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  // stall counter register
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) stall_cnt_q <= 16'd0;
    else stall_cnt_q <= stall_cnt_d;
  end
`endif
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: directed scoreboard bench for id_operand_stage with LOAD_LAT = 2
module tb_id_operand_stage;
  logic clk = 1'b0, clr_n = 1'b0;
  logic id_valid, ex_we, ex_load, mem_we, wb_we, flush;
  logic [4:0] ra_in, rb_in, ra, rb, ex_rd, mem_rd, wb_rd;
  logic [31:0] pa, pb, ex_result, mem_data, wb_data, opa, opb;
  logic stall, op_valid;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] sc_exp = 16'd0;
`ifdef ID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  int tests = 0, fails = 0;
  typedef struct {logic [31:0] a, b; logic v; logic [1:0] fa, fb;} exp_t;
  exp_t q[$];

  id_operand_stage #(.WIDTH(32), .AW(5), .LOAD_LAT(2)) dut (
    .Clk(clk), .Clr_n(clr_n), .ID_valid(id_valid), .RA_in(ra_in), .RB_in(rb_in),
    .RA(ra), .RB(rb), .PA(pa), .PB(pb), .EX_rd(ex_rd), .EX_we(ex_we), .EX_load(ex_load),
    .EX_result(ex_result), .MEM_rd(mem_rd), .MEM_we(mem_we), .MEM_data(mem_data),
    .WB_rd(wb_rd), .WB_we(wb_we), .WB_data(wb_data), .Flush(flush), .Stall(stall),
    .OPA(opa), .OPB(opb), .OP_valid(op_valid), .FWD_A(fwd_a), .FWD_B(fwd_b)
`ifdef ID_STALL_CNT_EN
    , .STALL_CNT(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_cnt(input string tag);
`ifdef ID_STALL_CNT_EN
    chk({tag, "/stall_cnt"}, 32'(stall_cnt), 32'(sc_exp));
`else
    if (tag.len() == 0) $display("[TB] empty tag");
`endif
  endtask

  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic v, input logic [1:0] fa, input logic [1:0] fb, input logic st);
    exp_t e;
    q.push_back('{a, b, v, fa, fb});
    #1 chk({tag, "/stall"}, 32'(stall), 32'(st));
    if (st && sc_exp != 16'hFFFF) sc_exp++;
    @(posedge clk);
    #1 e = q.pop_front();
    chk({tag, "/opa"}, opa, e.a);
    chk({tag, "/opb"}, opb, e.b);
    chk({tag, "/valid"}, 32'(op_valid), 32'(e.v));
    chk({tag, "/fwd_a"}, 32'(fwd_a), 32'(e.fa));
    chk({tag, "/fwd_b"}, 32'(fwd_b), 32'(e.fb));
    chk_cnt(tag);
    @(negedge clk);
  endtask

  initial begin
    {id_valid, ex_we, ex_load, mem_we, wb_we, flush} = '0;
    {ra_in, rb_in, ex_rd, mem_rd, wb_rd} = '0;
    {pa, pb, ex_result, mem_data, wb_data} = '0;
    @(negedge clk);
    #1 chk("reset/opa", opa, 32'h0);
    chk("reset/valid", 32'(op_valid), 32'h0);
    chk("reset/stall", 32'(stall), 32'h0);
    chk("reset/fwd", 32'({fwd_a, fwd_b}), 32'h0);
    chk_cnt("reset");
    @(negedge clk);
    clr_n = 1'b1;
    id_valid = 1'b1; ra_in = 5'd3; rb_in = 5'd0; pa = 32'h11; pb = 32'h22;
    #1 chk("comb/ra", 32'(ra), 32'd3);
    chk("comb/rb", 32'(rb), 32'd0);
    step("rf", 32'h11, 32'h0, 1, 0, 0, 0);
    ex_we = 1; ex_rd = 5'd3; ex_result = 32'hAA; mem_we = 1; mem_rd = 5'd3; mem_data = 32'hBB;
    step("ex_over_mem", 32'hAA, 32'h0, 1, 3, 0, 0);
    ex_we = 0;
    step("mem", 32'hBB, 32'h0, 1, 2, 0, 0);
    mem_we = 0; wb_we = 1; wb_rd = 5'd5; wb_data = 32'h55; rb_in = 5'd5; pb = 32'h0;
    step("wb", 32'h11, 32'h55, 1, 0, 1, 0);
    rb_in = 5'd0;
    step("src0_b", 32'h11, 32'h0, 1, 0, 0, 0);
    ra_in = 5'd0; wb_rd = 5'd0; pa = 32'h99;
    step("src0_match", 32'h0, 32'h0, 1, 0, 0, 0);
    wb_we = 0; ra_in = 5'd3; pa = 32'h11; id_valid = 0;
    step("invalid", 32'h11, 32'h0, 0, 0, 0, 0);
    id_valid = 1; ex_we = 1; ex_load = 1; ex_rd = 5'd0; ra_in = 5'd0; rb_in = 5'd4; pb = 32'h44;
    step("load_rd0", 32'h0, 32'h44, 1, 0, 0, 0);
    ex_rd = 5'd7; ra_in = 5'd7; rb_in = 5'd0;
    step("hazard1", 32'h0, 32'h0, 0, 0, 0, 1);
    step("hold", 32'h0, 32'h0, 0, 0, 0, 1);
    ex_we = 0; ex_load = 0; mem_we = 1; mem_rd = 5'd7; mem_data = 32'hC0;
    step("after_load", 32'hC0, 32'h0, 1, 2, 0, 0);
    mem_we = 0; ex_we = 1; ex_load = 1; ex_rd = 5'd9; ra_in = 5'd9; rb_in = 5'd9;
    step("hazard_ab", 32'h0, 32'h0, 0, 0, 0, 1);
    step("hold_ab", 32'h0, 32'h0, 0, 0, 0, 1);
    ex_rd = 5'd7; ra_in = 5'd0; rb_in = 5'd7;
    step("hazard_b", 32'h0, 32'h0, 0, 0, 0, 1);
    flush = 1;
    step("flush_hold", 32'h0, 32'h0, 0, 0, 0, 0);
    flush = 0; ex_we = 0; ex_load = 0; mem_we = 1; mem_rd = 5'd7; mem_data = 32'hC0;
    step("run_after_flush", 32'h0, 32'hC0, 1, 0, 2, 0);
    flush = 1;
    step("flush_run", 32'h0, 32'h0, 0, 0, 0, 0);
    flush = 0; mem_we = 0; ex_we = 1; ex_load = 1; ex_rd = 5'd7; ra_in = 5'd7; rb_in = 5'd0;
    step("hazard_rst", 32'h0, 32'h0, 0, 0, 0, 1);
    id_valid = 0; ex_we = 0; ex_load = 0;
    #1 chk("in_hold/stall", 32'(stall), 32'h1);
    #1 clr_n = 1'b0;
    sc_exp = 16'd0;
    #1 chk("async_rst/stall", 32'(stall), 32'h0);
    chk("async_rst/opa", opa, 32'h0);
    chk("async_rst/valid", 32'(op_valid), 32'h0);
    chk_cnt("async_rst");
    #1 clr_n = 1'b1;
    @(negedge clk);
    chk("released/stall", 32'(stall), 32'h0);
    id_valid = 1; pa = 32'h77;
    step("post_rst", 32'h77, 32'h0, 1, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
